alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one N-bit ALU datapath (AND/OR/XOR/ADD/SUB/PASS_B with N,Z,V,C flags) between two requesters.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers one result per cycle into a single-entry response slot, and maintains the architectural flags register.
- Sits between the decode/execute issue logic and the register-file writeback.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle when valid&ready.
- req0_op  in  3  opcode: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 PASS_B, 6-7 illegal.
- req0_a  in  N  operand A.
- req0_b  in  N  operand B.
- req0_set_flags  in  1  op updates flags register.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_set_flags: same as requester 0, for requester 1.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer takes the response when valid&ready.
- rsp_id  out  1  requester that issued the op.
- rsp_result  out  N  registered ALU result.
- rsp_flags  out  4  flags of this op, {N,Z,V,C}.
- rsp_err  out  1  op was illegal.
- flags_n_z_v_c  out  4  architectural flags register.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0000, rsp_err 0, flags_n_z_v_c 0000, last_grant 1 (so requester 0 wins the first tie).
- Slot state:
  - EMPTY: rsp_valid=0. FULL: rsp_valid=1.
  - can_accept = EMPTY | (FULL & rsp_ready).
- Grant (combinational):
  - Only one valid → that requester.
  - Both valid → the requester != last_grant.
  - reqX_ready = can_accept & granted(X). At most one ready is high per cycle.
  - Ready may depend on valid; valid must not depend on ready.
- Accept edge:
  - Capture result, flags, id and err into the slot.
  - Set last_grant = id.
  - If set_flags=1 and op is legal, update flags_n_z_v_c on the same edge.
  - Latency: accepted at edge t → rsp_valid high after edge t; throughput is 1 op/cycle with rsp_ready=1.
- Transitions:
  - EMPTY → FULL on accept.
  - FULL & rsp_ready & no accept → EMPTY.
  - FULL & rsp_ready & accept → FULL with new contents (back-to-back).
  - FULL & !rsp_ready → hold every rsp_* output stable and keep both readys low.
- Arithmetic (width N, operands unsigned for C, two's complement for V):
  - N = result[N-1]; Z = (result == 0).
  - AND/OR/XOR/PASS_B: V=0, C=0.
  - ADD: C = carry out of bit N-1; V = (a[N-1]==b[N-1]) & (result[N-1]!=a[N-1]).
  - SUB: result = a-b; C = 1 iff a >= b unsigned (no borrow); V = (a[N-1]!=b[N-1]) & (result[N-1]!=a[N-1]).
  - Illegal op (6, 7): result 0, rsp_flags 0100, rsp_err=1, flags register never updated, last_grant still advances.
- Wrap-around: ADD/SUB wrap modulo 2^N.
- Reset mid-operation: pending response discarded, flags cleared, and arbitration restarts with requester 0 winning the first tie.
- Requesters may change valid/operands while not granted; no stickiness is required.

Decomposition:
- Shared package (alu_pkg):
  - opcode constants OP_AND..OP_PASS_B;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0;
  - reset value of the flags register.
- One combinational sub-module, alu_core #(N): inputs op, a, b; outputs result, flags, err.
  - The arbiter holds only the muxing, grant logic and registers.

Test Plan (N=8):
- Requester 0 only: XOR a=3, b=4, set_flags=1, rsp_ready=1 → next cycle rsp_result=00000111, rsp_flags=0000, rsp_id=0, flags register 0000.
- ADD 127+1, set_flags=1 → result 10000000, rsp_flags=1010, flags register 1010; then SUB 5-5, set_flags=0 → result 0, rsp_flags=0101, flags register stays 1010.
- Both requesters valid continuously for 4 cycles from reset, rsp_ready=1 → rsp_id sequence 0,1,0,1, one accept per cycle, never both readys high.
- rsp_ready held 0 for 3 cycles with the slot FULL → req0_ready/req1_ready low and rsp_* stable; rsp_ready=1 → drain and accept a new op on the same edge.
- Illegal op 7, set_flags=1 → rsp_err=1, rsp_result=0, rsp_flags=0100, flags register unchanged.
- Assert rst_n low asynchronously while rsp_valid=1 → rsp_valid and flags register go 0 immediately without a clock edge; after release a simultaneous request is granted to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and flag reset/illegal values.
// Imported by the ALU core, the arbiter and the bench.
package alu_pkg;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_XOR    = 3'd2;
    localparam logic [2:0] OP_ADD    = 3'd3;
    localparam logic [2:0] OP_SUB    = 3'd4;
    localparam logic [2:0] OP_PASS_B = 3'd5;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    localparam logic [3:0] FLAGS_RST     = 4'b0000;
    // Illegal ops report a zero result, so only Z is set.
    localparam logic [3:0] FLAGS_ILLEGAL = 4'b0100;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic flags_write_en(input logic set_flags, input logic err);
        return set_flags & ~err;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two issue ports and one writeback port of the shared ALU.
// master drives requests and consumes responses; slave is the arbiter.
interface alu_share_arbiter_if #(parameter int N = 8);

    logic         req0_valid;
    logic         req0_ready;
    logic [2:0]   req0_op;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req0_set_flags;

    logic         req1_valid;
    logic         req1_ready;
    logic [2:0]   req1_op;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         req1_set_flags;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_err;
    logic [3:0]   flags_n_z_v_c;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_set_flags,
        output req1_valid, req1_op, req1_a, req1_b, req1_set_flags,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, flags_n_z_v_c
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_set_flags,
        input  req1_valid, req1_op, req1_a, req1_b, req1_set_flags,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, flags_n_z_v_c
    );

endinterface

// File: rtl/alu_core.sv
// N-bit ALU: AND/OR/XOR/ADD/SUB/PASS_B producing result and {N,Z,V,C}.
// Latency: purely combinational.
// Backpressure: none; result follows inputs every cycle.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         err
);

    logic [N:0] wide;

    always_comb begin
        result = '0;
        flags  = FLAGS_RST;
        err    = 1'b0;
        wide   = '0;
        case (op)
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_PASS_B: result = b;
            OP_ADD: begin
                wide           = {1'b0, a} + {1'b0, b};
                result         = wide[N-1:0];
                flags[FLAG_C]  = wide[N];
                flags[FLAG_V]  = (a[N-1] == b[N-1]) && (wide[N-1] != a[N-1]);
            end
            OP_SUB: begin
                // Extra top bit is the borrow; C is its inverse (no-borrow convention).
                wide           = {1'b0, a} - {1'b0, b};
                result         = wide[N-1:0];
                flags[FLAG_C]  = ~wide[N];
                flags[FLAG_V]  = (a[N-1] != b[N-1]) && (wide[N-1] != a[N-1]);
            end
            default:   err = 1'b1;
        endcase

        if (err) begin
            flags = FLAGS_ILLEGAL;
        end else begin
            flags[FLAG_N] = result[N-1];
            flags[FLAG_Z] = (result == '0);
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters, single-entry response slot, flags register.
// Latency: op accepted on edge t appears in the response slot right after edge t; 1 op/cycle.
// Backpressure: both readys drop while the slot is full and rsp_ready is low; slot contents hold.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arbiter_if.slave bus
);

    typedef struct packed {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         set_flags;
    } req_t;

    typedef struct packed {
        logic         id;
        logic [N-1:0] result;
        logic [3:0]   flags;
        logic         err;
    } rsp_t;

    slot_state_t  slot;
    logic         last_grant;
    rsp_t         rsp_q;
    logic [3:0]   flags_q;

    req_t         req0;
    req_t         req1;
    req_t         sel;
    logic         grant_id;
    logic         can_accept;
    logic         accept;

    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         alu_err;

    assign req0 = '{op: bus.req0_op, a: bus.req0_a, b: bus.req0_b, set_flags: bus.req0_set_flags};
    assign req1 = '{op: bus.req1_op, a: bus.req1_a, b: bus.req1_b, set_flags: bus.req1_set_flags};

    // On a tie the requester that did not win last time goes; otherwise the lone valid wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = bus.req1_valid;
        end
    end

    assign can_accept     = (slot == SLOT_EMPTY) || bus.rsp_ready;
    assign accept         = can_accept && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = can_accept && bus.req0_valid && !grant_id;
    assign bus.req1_ready = can_accept && bus.req1_valid &&  grant_id;
    assign sel            = grant_id ? req1 : req0;

    alu_core #(.N(N)) u_alu_core (
        .op     (sel.op),
        .a      (sel.a),
        .b      (sel.b),
        .result (alu_result),
        .flags  (alu_flags),
        .err    (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot       <= SLOT_EMPTY;
            last_grant <= 1'b1;
            rsp_q      <= '0;
            flags_q    <= FLAGS_RST;
        end else begin
            case (slot)
                SLOT_EMPTY: begin
                    if (accept) begin
                        slot <= SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (bus.rsp_ready && !accept) begin
                        slot <= SLOT_EMPTY;
                    end
                end
                default: slot <= SLOT_EMPTY;
            endcase

            if (accept) begin
                rsp_q      <= '{id: grant_id, result: alu_result, flags: alu_flags, err: alu_err};
                last_grant <= grant_id;
                if (flags_write_en(sel.set_flags, alu_err)) begin
                    flags_q <= alu_flags;
                end
            end
        end
    end

    assign bus.rsp_valid     = (slot == SLOT_FULL);
    assign bus.rsp_id        = rsp_q.id;
    assign bus.rsp_result    = rsp_q.result;
    assign bus.rsp_flags     = rsp_q.flags;
    assign bus.rsp_err       = rsp_q.err;
    assign bus.flags_n_z_v_c = flags_q;

endmodule
